// File: rtl/seq_compare.sv
// seq_compare: multi-cycle magnitude comparator.
// Latches two operands on start, scans them MSB-first one SLICE per cycle,
// stops at the first differing slice and returns less/equal flags plus a
// boolean selected by a 3-bit compare op (signed or unsigned).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; result/flag outputs hold last outcome
// SCAN  | comparing slice r_idx of the latched operands, one per cycle
// DONE  | result valid, done_o pulses for one cycle, then back to IDLE
module seq_compare #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [2:0]       comp_i,
    input  logic             signed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             result_o,
    output logic             is_less_o,
    output logic             is_equal_o
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [2:0]        r_comp;
    logic              r_signed;
    logic [IDXW-1:0]   r_idx;
    logic              r_less;
    logic              r_equal;
    logic              r_result;

    logic [SLICE-1:0]  w_a_slice;
    logic [SLICE-1:0]  w_b_slice;
    logic              w_top;
    logic              w_last;
    logic              w_slice_ne;
    logic              w_sign_split;
    logic              w_less_now;
    logic              w_finish;
    logic              w_flag_less;
    logic              w_flag_equal;
    logic              w_result_now;

    // Boolean outcome of a compare op given the final less/equal flags.
    function automatic logic op_result(input logic [2:0] op, input logic l, input logic e);
        logic r;
        r = 1'b0;
        case (op)
            3'b000:  r = l;
            3'b001:  r = !l && !e;
            3'b010:  r = l || e;
            3'b011:  r = !l;
            3'b100:  r = e;
            3'b101:  r = !e;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Select the current slice of each latched operand (constant-index mux).
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_slice = r_a[i*SLICE +: SLICE];
                w_b_slice = r_b[i*SLICE +: SLICE];
            end
        end
    end

    // Per-slice decision; sign bits only matter on the top slice in signed mode.
    always_comb begin
        w_top        = (r_idx == IDX_TOP);
        w_last       = (r_idx == '0);
        w_slice_ne   = (w_a_slice != w_b_slice);
        w_sign_split = r_signed && w_top && (w_a_slice[SLICE-1] != w_b_slice[SLICE-1]);
        w_less_now   = w_sign_split ? w_a_slice[SLICE-1] : (w_a_slice < w_b_slice);
        w_finish     = (r_state == ST_SCAN) && (w_slice_ne || w_last);
        w_flag_less  = w_slice_ne ? w_less_now : 1'b0;
        w_flag_equal = !w_slice_ne;
        w_result_now = op_result(r_comp, w_flag_less, w_flag_equal);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_finish) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand latch, slice index walk and result capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_comp   <= '0;
            r_signed <= 1'b0;
            r_idx    <= IDX_TOP;
            r_less   <= 1'b0;
            r_equal  <= 1'b0;
            r_result <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start_i) begin
                r_a      <= src1_i;
                r_b      <= src2_i;
                r_comp   <= comp_i;
                r_signed <= signed_i;
                r_idx    <= IDX_TOP;
            end else if (w_finish) begin
                r_less   <= w_flag_less;
                r_equal  <= w_flag_equal;
                r_result <= w_result_now;
            end else if (r_state == ST_SCAN) begin
                r_idx    <= r_idx - IDXW'(1);
            end
        end
    end

    // Outputs straight from registers.
    always_comb begin
        busy_o     = (r_state != ST_IDLE);
        done_o     = (r_state == ST_DONE);
        result_o   = r_result;
        is_less_o  = r_less;
        is_equal_o = r_equal;
    end

endmodule

// File: tb/tb_seq_compare.sv
// Scoreboard bench for seq_compare: stimulus pushes model predictions,
// a negedge monitor pops and compares whenever done_o is seen.
module tb_seq_compare;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk_i;
    logic             rst_i;
    logic             start_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [2:0]       comp_i;
    logic             signed_i;
    logic             busy_o;
    logic             done_o;
    logic             result_o;
    logic             is_less_o;
    logic             is_equal_o;

    typedef struct {
        bit less;
        bit equal;
        bit result;
        int lat;
        int start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total;
    int   n_bad;
    int   cyc;
    bit   last_less;
    bit   last_equal;
    bit   last_result;

    seq_compare #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .comp_i     (comp_i),
        .signed_i   (signed_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .is_less_o  (is_less_o),
        .is_equal_o (is_equal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: whole-word comparison; latency from position of the highest differing slice.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [2:0] op, input bit sgn);
        exp_t e;
        int   k;
        e.less  = sgn ? ($signed(a) < $signed(b)) : (a < b);
        e.equal = (a == b);
        k = NSLICE;
        for (int j = NSLICE - 1; j >= 0; j--) begin
            if (a[j*SLICE +: SLICE] != b[j*SLICE +: SLICE]) begin
                k = NSLICE - j;
                break;
            end
        end
        e.lat = k + 1;
        case (op)
            3'd0:    e.result = e.less;
            3'd1:    e.result = !e.less && !e.equal;
            3'd2:    e.result = e.less || e.equal;
            3'd3:    e.result = !e.less;
            3'd4:    e.result = e.equal;
            3'd5:    e.result = !e.equal;
            default: e.result = 1'b0;
        endcase
        e.start_cyc = 0;
        return e;
    endfunction

    // Monitor: compare every completed operation against the scoreboard.
    always @(negedge clk_i) begin
        if (rst_i && done_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("is_less", 32'(is_less_o), 32'(e.less));
                chk("is_equal", 32'(is_equal_o), 32'(e.equal));
                chk("result", 32'(result_o), 32'(e.result));
                chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                chk("busy_in_done", 32'(busy_o), 32'd1);
                last_less   = e.less;
                last_equal  = e.equal;
                last_result = e.result;
            end
        end
    end

    // Issue one operation from IDLE; optionally poke start again while busy.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] op, input bit sgn, input bit poke);
        exp_t e;
        int   n;
        e = model(a, b, op, sgn);
        e.start_cyc = cyc;
        src1_i   = a;
        src2_i   = b;
        comp_i   = op;
        signed_i = sgn;
        start_i  = 1'b1;
        exp_q.push_back(e);
        @(negedge clk_i);
        start_i = 1'b0;
        if (poke) begin
            chk("busy_after_start", 32'(busy_o), 32'd1);
            src1_i   = ~a;
            src2_i   = a;
            comp_i   = op ^ 3'd1;
            signed_i = ~sgn;
            start_i  = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
        end
        n = 0;
        while (busy_o && n < NSLICE + 6) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) begin
            chk("busy_timeout", 32'd1, 32'd0);
        end
        chk("hold_less", 32'(is_less_o), 32'(e.less));
        chk("hold_equal", 32'(is_equal_o), 32'(e.equal));
        chk("hold_result", 32'(result_o), 32'(e.result));
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        n_total  = 0;
        n_bad    = 0;
        cyc      = 0;
        rst_i    = 1'b0;
        start_i  = 1'b0;
        src1_i   = '0;
        src2_i   = '0;
        comp_i   = '0;
        signed_i = 1'b0;

        // Reset held for three cycles.
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_flags", {29'd0, result_o, is_less_o, is_equal_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_flags", {29'd0, result_o, is_less_o, is_equal_o}, 32'd0);

        // Directed cases; first one starts on the first cycle after release.
        run_op(32'h12345678, 32'h12345678, 3'b100, 1'b0, 1'b0);
        run_op(32'h01000000, 32'h02000000, 3'b000, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b011, 1'b1, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b011, 1'b0, 1'b0);
        for (int op = 0; op < 8; op++) begin
            run_op(32'h000000FE, 32'h000000FF, 3'(op), 1'b0, 1'b0);
        end
        run_op(32'h7F000000, 32'h80000000, 3'b000, 1'b1, 1'b0);
        run_op(32'h80000010, 32'h80000020, 3'b000, 1'b1, 1'b0);

        // Start while busy must be ignored.
        run_op(32'h00001234, 32'h00001235, 3'b000, 1'b0, 1'b1);
        run_op(32'hA5A5A5A5, 32'hA5A5A5A5, 3'b100, 1'b1, 1'b1);

        // Reset during the second SCAN cycle aborts with no done.
        src1_i   = 32'hCAFEF00D;
        src2_i   = 32'hCAFEF00D;
        comp_i   = 3'b100;
        signed_i = 1'b0;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_flags", {29'd0, result_o, is_less_o, is_equal_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (NSLICE + 4) @(negedge clk_i);
        chk("abort_idle_busy", 32'(busy_o), 32'd0);

        // Randomized operations with controlled slice agreement.
        for (int t = 0; t < 200; t++) begin
            int mode;
            int j;
            a    = $urandom;
            b    = a;
            mode = $urandom_range(0, 4);
            case (mode)
                0: b = $urandom;
                1: begin
                    j = $urandom_range(0, NSLICE - 1);
                    b[j*SLICE +: SLICE] = 8'($urandom);
                end
                2: b = a;
                3: b = a ^ 32'h80000000;
                default: begin
                    j = $urandom_range(0, WIDTH - 1);
                    b[j] = ~b[j];
                end
            endcase
            run_op(a, b, 3'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        repeat (4) @(negedge clk_i);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
